glenn_pwm_generator: RTL

Downstream consumer of the 8-bit up/down counter: takes the counter's `out_Count` value as a PWM duty setting and drives a single PWM output on the system clock. The counter value arrives from a separate clock (`in_Counter_Clk`) and is not trusted until it is synchronised and stable. Duty changes are applied only at period boundaries, so the output never emits a glitched or truncated pulse.

---
 rtl/glenn_pwm_generator.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/glenn_pwm_generator.sv
// glenn_pwm_generator
// PWM output driven from a duty value that arrives from a foreign clock domain.
// The duty word is synchronised, accepted only once it has been stable for two
// consecutive samples, and applied to the output only at period boundaries.
// A PWM period is 255 ticks, and one tick lasts PRESCALE system clocks.

module glenn_pwm_generator #(
  parameter int PRESCALE = 4
) (
  input  logic       in_Clk,
  input  logic       in_Reset_n,
  input  logic       in_Enable,
  input  logic [7:0] in_Duty,
  output logic       out_Pwm,
  output logic       out_PeriodStart,
  output logic [7:0] out_DutyActive
);

  // The prescaler is at least one bit wide, so PRESCALE = 1 still gets a legal vector.
  localparam int              PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESCALE - 1);
  // period_cnt runs 0..254, so a duty of 255 keeps the output high for the whole period.
  localparam logic [7:0]      CNT_LAST   = 8'd254;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e        state_q, state_d;

  logic [7:0]    sync1_q, sync2_q, sync_prev_q;
  logic [7:0]    pending_q, pending_d;

  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          pwm_q, pwm_d;
  logic          ps_q, ps_d;
  logic [7:0]    duty_q, duty_d;
  logic          tick;

  assign tick = (presc_q == PRESC_LAST);

  // Accept a synchronised value only after it has been identical on two
  // consecutive samples. A counter running faster than in_Clk therefore
  // leaves the previously accepted value in place.
  always_comb begin
    pending_d = pending_q;
    if (sync2_q == sync_prev_q) begin
      pending_d = sync2_q;
    end
  end

  // Double-flop synchroniser, stability history, and the accepted duty value.
  always_ff @(posedge in_Clk or negedge in_Reset_n) begin
    if (!in_Reset_n) begin
      sync1_q     <= 8'd0;
      sync2_q     <= 8'd0;
      sync_prev_q <= 8'd0;
      pending_q   <= 8'd0;
    end else begin
      sync1_q     <= in_Duty;
      sync2_q     <= sync1_q;
      sync_prev_q <= sync2_q;
      pending_q   <= pending_d;
    end
  end

  // Next state and datapath values: prescaler, period counter, duty latch and
  // the registered PWM and period-start outputs.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    cnt_d   = cnt_q;
    pwm_d   = pwm_q;
    ps_d    = 1'b0;
    duty_d  = duty_q;

    case (state_q)
      IDLE: begin
        presc_d = '0;
        cnt_d   = 8'd0;
        pwm_d   = 1'b0;
        duty_d  = pending_q;
        if (in_Enable) begin
          // Flag the period start in the first RUN cycle; the counters are already zero.
          state_d = RUN;
          ps_d    = 1'b1;
        end
      end

      RUN: begin
        if (!in_Enable) begin
          // Abandon the period at once. No partial pulse is completed.
          state_d = IDLE;
          presc_d = '0;
          cnt_d   = 8'd0;
          pwm_d   = 1'b0;
        end else begin
          // The output is one clock behind period_cnt, so each period starts with a registered compare.
          pwm_d = (cnt_q < duty_q);
          if (tick) begin
            presc_d = '0;
            if (cnt_q == CNT_LAST) begin
              // Wrap tick: latch the value accepted before this cycle as the new duty.
              cnt_d  = 8'd0;
              duty_d = pending_q;
              ps_d   = 1'b1;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. An asynchronous reset aborts any period in progress.
  always_ff @(posedge in_Clk or negedge in_Reset_n) begin
    if (!in_Reset_n) begin
      state_q <= IDLE;
      presc_q <= '0;
      cnt_q   <= 8'd0;
      pwm_q   <= 1'b0;
      ps_q    <= 1'b0;
      duty_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      pwm_q   <= pwm_d;
      ps_q    <= ps_d;
      duty_q  <= duty_d;
    end
  end

  assign out_Pwm         = pwm_q;
  assign out_PeriodStart = ps_q;
  assign out_DutyActive  = duty_q;

endmodule
